// File: rtl/dequant_zigzag_reorder_if.sv
// Stream and table-programming bundle for the dequantizer / zigzag reorder front end.
// The design sits on the slave modport; the producer/consumer side uses master.
interface dequant_zigzag_reorder_if #(
    parameter int N      = 8,
    parameter int COEF_W = 9,
    parameter int Q_W    = 8,
    parameter int OUT_W  = COEF_W + Q_W,
    parameter int IDX_W  = $clog2(N * N)
);
    logic                     q_we;
    logic [IDX_W-1:0]         q_addr;
    logic [Q_W-1:0]           q_data;

    logic                     in_valid;
    logic                     in_ready;
    logic signed [COEF_W-1:0] in_coef;
    logic                     in_last;

    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_coef;
    logic [IDX_W-1:0]         out_index;
    logic                     out_last;
    logic                     err_framing;

    modport master (
        output q_we, q_addr, q_data,
        output in_valid, in_coef, in_last,
        output out_ready,
        input  in_ready,
        input  out_valid, out_coef, out_index, out_last, err_framing
    );

    modport slave (
        input  q_we, q_addr, q_data,
        input  in_valid, in_coef, in_last,
        input  out_ready,
        output in_ready,
        output out_valid, out_coef, out_index, out_last, err_framing
    );
endinterface

// File: rtl/dequant_zigzag_reorder.sv
// Dequantizes a zigzag-ordered coefficient block and writes it into one of two
// ping-pong banks in raster order; the other bank drains through a single output register.
module dequant_zigzag_reorder #(
    parameter int N      = 8,
    parameter int COEF_W = 9,
    parameter int Q_W    = 8,
    parameter int OUT_W  = COEF_W + Q_W,
    parameter int IDX_W  = $clog2(N * N)
) (
    input  logic                    clk,
    input  logic                    rst,
    dequant_zigzag_reorder_if.slave bus
);
    localparam int              NN       = N * N;
    localparam int              RC_W     = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);
    localparam logic [RC_W-1:0]  EDGE     = RC_W'(N - 1);

    typedef enum logic [1:0] {
        B_EMPTY    = 2'd0,
        B_FILLING  = 2'd1,
        B_FULL     = 2'd2,
        B_DRAINING = 2'd3
    } bank_st_e;

    // ---------------- quantization table ----------------
    logic [Q_W-1:0] q_tab [NN];

    generate
        for (genvar gi = 0; gi < NN; gi++) begin : g_qtab
            logic [Q_W-1:0] step_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    step_q <= Q_W'(1);
                end else if (bus.q_we && (bus.q_addr == IDX_W'(gi))) begin
                    step_q <= bus.q_data;
                end
            end
            assign q_tab[gi] = step_q;
        end
    endgenerate

    // ---------------- state ----------------
    bank_st_e          bank_q [2];
    bank_st_e          bank_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [RC_W-1:0]   row_q, row_d;
    logic [RC_W-1:0]   col_q, col_d;
    logic              dir_up_q, dir_up_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic              err_q, err_d;

    logic                    out_valid_q;
    logic signed [OUT_W-1:0] out_coef_q;
    logic [IDX_W-1:0]        out_index_q;
    logic                    out_last_q;

    logic signed [OUT_W-1:0] bank_mem [2][NN];

    logic                    in_ready_w;
    logic                    rd_avail_w;
    logic                    load_w;
    logic                    wr_fire_w;
    logic                    wr_end_w;
    logic                    rd_end_w;
    logic [IDX_W-1:0]        zz_w;
    logic signed [OUT_W-1:0] coef_ext_w;
    logic signed [OUT_W-1:0] step_ext_w;
    logic signed [OUT_W-1:0] prod_w;

    // ---------------- bank FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q[0] <= B_EMPTY;
            bank_q[1] <= B_EMPTY;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            dir_up_q  <= 1'b1;
            cnt_q     <= '0;
            rd_idx_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            row_q     <= row_d;
            col_q     <= col_d;
            dir_up_q  <= dir_up_d;
            cnt_q     <= cnt_d;
            rd_idx_q  <= rd_idx_d;
            err_q     <= err_d;
        end
    end

    // ---------------- bank FSM: outputs (handshake qualifiers) ----------------
    always_comb begin
        in_ready_w = (bank_q[wr_ptr_q] != B_FULL) && (bank_q[wr_ptr_q] != B_DRAINING);
        rd_avail_w = (bank_q[rd_ptr_q] == B_FULL) || (bank_q[rd_ptr_q] == B_DRAINING);
        load_w     = rd_avail_w && (!out_valid_q || bus.out_ready);
        wr_fire_w  = bus.in_valid && in_ready_w;
        wr_end_w   = wr_fire_w && (cnt_q == LAST_IDX);
        rd_end_w   = load_w && (rd_idx_q == LAST_IDX);
    end

    // ---------------- bank FSM: next state ----------------
    // Writer and reader never share a bank, so both updates can land in one cycle.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_d[b] = bank_q[b];
            if (wr_fire_w && (wr_ptr_q == 1'(b))) begin
                bank_d[b] = wr_end_w ? B_FULL : B_FILLING;
            end
            if (load_w && (rd_ptr_q == 1'(b))) begin
                bank_d[b] = rd_end_w ? B_EMPTY : B_DRAINING;
            end
        end
        rd_ptr_d = rd_end_w ? ~rd_ptr_q : rd_ptr_q;
        rd_idx_d = rd_idx_q;
        if (load_w) begin
            rd_idx_d = rd_end_w ? '0 : rd_idx_q + 1'b1;
        end
        err_d = err_q | (wr_fire_w && (bus.in_last != (cnt_q == LAST_IDX)));
    end

    // ---------------- zigzag walker and write counter ----------------
    always_comb begin
        row_d    = row_q;
        col_d    = col_q;
        dir_up_d = dir_up_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        if (wr_end_w) begin
            row_d    = '0;
            col_d    = '0;
            dir_up_d = 1'b1;
            cnt_d    = '0;
            wr_ptr_d = ~wr_ptr_q;
        end else if (wr_fire_w) begin
            cnt_d = cnt_q + 1'b1;
            if (dir_up_q) begin
                if (col_q == EDGE) begin
                    row_d    = row_q + 1'b1;
                    dir_up_d = 1'b0;
                end else if (row_q == '0) begin
                    col_d    = col_q + 1'b1;
                    dir_up_d = 1'b0;
                end else begin
                    row_d = row_q - 1'b1;
                    col_d = col_q + 1'b1;
                end
            end else begin
                if (row_q == EDGE) begin
                    col_d    = col_q + 1'b1;
                    dir_up_d = 1'b1;
                end else if (col_q == '0) begin
                    row_d    = row_q + 1'b1;
                    dir_up_d = 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                    col_d = col_q - 1'b1;
                end
            end
        end
    end

    // ---------------- dequantize and store ----------------
    // Operands widened to the full output width so the low bits of the product are exact.
    assign zz_w       = IDX_W'(int'(row_q) * N + int'(col_q));
    assign coef_ext_w = {{Q_W{bus.in_coef[COEF_W-1]}}, bus.in_coef};
    assign step_ext_w = {{COEF_W{1'b0}}, q_tab[zz_w]};
    assign prod_w     = coef_ext_w * step_ext_w;

    always_ff @(posedge clk) begin
        if (wr_fire_w) begin
            bank_mem[wr_ptr_q][zz_w] <= prod_w;
        end
    end

    // ---------------- output register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_coef_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
        end else if (load_w) begin
            out_valid_q <= 1'b1;
            out_coef_q  <= bank_mem[rd_ptr_q][rd_idx_q];
            out_index_q <= rd_idx_q;
            out_last_q  <= (rd_idx_q == LAST_IDX);
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready    = in_ready_w;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_coef    = out_coef_q;
    assign bus.out_index   = out_index_q;
    assign bus.out_last    = out_last_q;
    assign bus.err_framing = err_q;

endmodule

// File: tb/tb_dequant_zigzag_reorder.sv
// Directed bench for dequant_zigzag_reorder: per-block expected values come from a
// fixed JPEG zigzag table and the bench's own copy of the quantization table.
module tb_dequant_zigzag_reorder;
    localparam int N      = 8;
    localparam int COEF_W = 9;
    localparam int Q_W    = 8;
    localparam int OUT_W  = COEF_W + Q_W;
    localparam int IDX_W  = 6;
    localparam int NN     = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dequant_zigzag_reorder_if #(.N(N), .COEF_W(COEF_W), .Q_W(Q_W)) bus ();

    dequant_zigzag_reorder #(.N(N), .COEF_W(COEF_W), .Q_W(Q_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // zigzag position of each raster entry (standard 8x8 table)
    int zz_of_raster [64] = '{
         0,  1,  5,  6, 14, 15, 27, 28,
         2,  4,  7, 13, 16, 26, 29, 42,
         3,  8, 12, 17, 25, 30, 41, 43,
         9, 11, 18, 24, 31, 40, 44, 53,
        10, 19, 23, 32, 39, 45, 52, 54,
        20, 22, 33, 38, 46, 51, 55, 60,
        21, 34, 37, 47, 50, 56, 59, 61,
        35, 36, 48, 49, 57, 58, 62, 63
    };
    int ras_of_zz [64];

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q [$];
    int mq [64];
    int stim [64];
    int cyc = 0;
    int t_first_in, t_last_in, t_first_out, t_last_out;
    bit arm = 1'b0;
    bit rdy_toggle = 1'b0;
    int blk_in = 0;
    int blk_out = 0;

    task automatic check_eq(input string tag, input logic signed [63:0] got,
                            input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rdy_toggle ? ~bus.out_ready : 1'b1;
        end
    end

    // output monitor: compares each accepted output against the scoreboard
    initial begin
        int out_cnt;
        int e;
        bit stall_prev;
        logic signed [63:0] held_coef;
        logic signed [63:0] held_idx;
        out_cnt = 0;
        stall_prev = 1'b0;
        held_coef = 0;
        held_idx = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                out_cnt = 0;
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check_eq("hold_coef", $signed(bus.out_coef), held_coef);
                    check_eq("hold_index", bus.out_index, held_idx);
                end
                stall_prev = bus.out_valid && !bus.out_ready;
                if (stall_prev) begin
                    held_coef = $signed(bus.out_coef);
                    held_idx = bus.out_index;
                end
                if (bus.out_valid && arm && t_first_out < 0) t_first_out = cyc;
                if (bus.out_valid && bus.out_ready) begin
                    t_last_out = cyc;
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_out", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("out_coef", $signed(bus.out_coef), e);
                        check_eq("out_index", bus.out_index, out_cnt);
                        check_eq("out_last", bus.out_last, (out_cnt == 63));
                        if (out_cnt == 63) begin
                            $display("block out #%0d complete at cycle %0d", blk_out, cyc);
                            blk_out++;
                        end
                        out_cnt = (out_cnt + 1) % 64;
                    end
                end
            end
        end
    end

    task automatic send_block(input int n, input int bad_k, input int wr_k,
                              input int wr_addr, input int wr_data);
        int blk_exp [64];
        int r;
        int tries;
        for (int i = 0; i < 64; i++) blk_exp[i] = 0;
        for (int k = 0; k < n; k++) begin
            bus.in_valid = 1'b1;
            bus.in_coef  = COEF_W'(stim[k]);
            bus.in_last  = (k == 63) || (k == bad_k);
            bus.q_we     = (k == wr_k);
            bus.q_addr   = IDX_W'(wr_addr);
            bus.q_data   = Q_W'(wr_data);
            @(negedge clk);
            if (bad_k >= 0 && k == bad_k) check_eq("err_before", bus.err_framing, 0);
            if (bad_k >= 0 && k == bad_k + 1) check_eq("err_after", bus.err_framing, 1);
            tries = 0;
            while (!bus.in_ready && tries < 1000) begin
                @(negedge clk);
                tries++;
            end
            if (tries >= 1000) begin
                check_eq("in_ready_timeout", 0, 1);
                bus.in_valid = 1'b0;
                bus.q_we = 1'b0;
                return;
            end
            if (t_first_in < 0) t_first_in = cyc;
            t_last_in = cyc;
            r = ras_of_zz[k];
            blk_exp[r] = stim[k] * mq[r];
            if (k == wr_k) mq[wr_addr] = wr_data;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.q_we     = 1'b0;
        if (n == 64) begin
            for (int i = 0; i < 64; i++) exp_q.push_back(blk_exp[i]);
        end
        $display("block in #%0d: %0d coefs sent, last accepted cycle %0d", blk_in, n, t_last_in);
        blk_in++;
    endtask

    task automatic prog_table(input int v);
        for (int i = 0; i < 64; i++) begin
            bus.q_we   = 1'b1;
            bus.q_addr = IDX_W'(i);
            bus.q_data = Q_W'(v);
            mq[i] = v;
            @(posedge clk);
            #1;
        end
        bus.q_we = 1'b0;
        $display("table programmed to %0d", v);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_eq("drain_done", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.q_we = 1'b0;
        bus.in_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 64; i++) mq[i] = 1;
        $display("reset applied at cycle %0d", cyc);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) ras_of_zz[zz_of_raster[i]] = i;
        bus.in_valid = 1'b0;
        bus.in_coef  = '0;
        bus.in_last  = 1'b0;
        bus.q_we     = 1'b0;
        bus.q_addr   = '0;
        bus.q_data   = '0;
        t_first_in = -1;
        t_first_out = -1;
        t_last_in = 0;
        t_last_out = 0;

        // 1: reset state
        @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_in_ready", bus.in_ready, 1);
        check_eq("rst_err", bus.err_framing, 0);
        check_eq("rst_out_coef", $signed(bus.out_coef), 0);
        check_eq("rst_out_index", bus.out_index, 0);
        check_eq("rst_out_last", bus.out_last, 0);
        @(posedge clk);
        #1;

        // 2: identity table, value k at zigzag position k; first output at +65
        for (int k = 0; k < 64; k++) stim[k] = k;
        t_first_in = -1;
        t_first_out = -1;
        arm = 1'b1;
        send_block(64, -1, -1, 0, 0);
        wait_drain();
        arm = 1'b0;
        check_eq("latency_first_out", t_first_out - t_first_in, 65);

        // table writes during a block: same-cycle collision uses old, later coefs use new
        for (int k = 0; k < 64; k++) stim[k] = k + 1;
        send_block(64, -1, 4, 9, 7);
        send_block(64, -1, 10, 25, 3);
        wait_drain();

        // 3: extreme product and a small negative case
        prog_table(255);
        for (int k = 0; k < 64; k++) stim[k] = -256;
        send_block(64, -1, -1, 0, 0);
        wait_drain();
        prog_table(2);
        for (int k = 0; k < 64; k++) stim[k] = -3;
        send_block(64, -1, -1, 0, 0);
        wait_drain();

        // 4: two back-to-back blocks with out_ready held high
        for (int k = 0; k < 64; k++) stim[k] = (k * 7) % 200 - 100;
        t_first_in = -1;
        t_first_out = -1;
        arm = 1'b1;
        send_block(64, -1, -1, 0, 0);
        for (int k = 0; k < 64; k++) stim[k] = -stim[k];
        send_block(64, -1, -1, 0, 0);
        check_eq("in_gapless", t_last_in - t_first_in, 127);
        wait_drain();
        arm = 1'b0;
        check_eq("stream_first_out", t_first_out - t_first_in, 65);
        check_eq("stream_last_out", t_last_out - t_first_in, 192);

        // 4b: same with out_ready toggling
        rdy_toggle = 1'b1;
        for (int k = 0; k < 64; k++) stim[k] = 50 - k;
        send_block(64, -1, -1, 0, 0);
        for (int k = 0; k < 64; k++) stim[k] = (k * 13) % 120 - 60;
        send_block(64, -1, -1, 0, 0);
        @(negedge clk);
        check_eq("inrdy_both_busy", bus.in_ready, 0);
        wait_drain();
        rdy_toggle = 1'b0;
        @(posedge clk);
        #1;

        // 5: early in_last sets the sticky framing error
        for (int k = 0; k < 64; k++) stim[k] = k - 32;
        send_block(64, 10, -1, 0, 0);
        wait_drain();
        check_eq("err_sticky", bus.err_framing, 1);

        // 6: reset mid-block discards the partial block
        for (int k = 0; k < 64; k++) stim[k] = k * 2 - 60;
        send_block(30, -1, -1, 0, 0);
        do_reset();
        @(negedge clk);
        check_eq("rst2_out_valid", bus.out_valid, 0);
        check_eq("rst2_err", bus.err_framing, 0);
        check_eq("rst2_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 64; k++) stim[k] = 100 - k * 3;
        send_block(64, -1, -1, 0, 0);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
